// File: rtl/spi_tx_arbiter.sv
// Two-requester round-robin arbiter feeding framed bytes to an SPI slave transmitter.
// Define SPI_TX_HDR_EN to prefix each frame with a {requester id, byte count} header byte.
module spi_tx_arbiter #(
   parameter int unsigned LEN_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   input  logic [7:0]       rd_data0,
   input  logic [7:0]       rd_data1,
   input  logic             send_complete,
   output logic [1:0]       gnt,
   output logic             rd_en,
   output logic [7:0]       tx_data,
   output logic             tx_load,
   output logic [1:0]       frame_done,
   output logic             busy
);

`ifdef SPI_TX_HDR_EN
   typedef enum logic [2:0] {StIdle, StHdr, StFetch, StLoad, StWaitTx, StDone} state_e;
`else
   typedef enum logic [2:0] {StIdle, StFetch, StLoad, StWaitTx, StDone} state_e;
`endif

   state_e           state_q, state_d;
   logic [1:0]       gnt_q, gnt_d;
   logic             id_q, id_d;
   logic             last_q, last_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_load_q, tx_load_d;
   logic [1:0]       frame_done_q, frame_done_d;

   logic             win_id;
   logic [LEN_W-1:0] win_len;
   logic [7:0]       rd_data_sel;

   // On a tie the requester that was not served last wins.
   assign win_id      = (req == 2'b11) ? ~last_q : req[1];
   assign win_len     = win_id ? len1 : len0;
   assign rd_data_sel = id_q ? rd_data1 : rd_data0;

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      id_d         = id_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      tx_data_d    = tx_data_q;
      tx_load_d    = 1'b0;
      frame_done_d = 2'b00;

      unique case (state_q)
         StIdle: begin
            if (req != 2'b00) begin
               gnt_d = {win_id, ~win_id};
               id_d  = win_id;
               cnt_d = win_len;
`ifdef SPI_TX_HDR_EN
               state_d = StHdr;
`else
               state_d = (win_len == '0) ? StDone : StFetch;
`endif
            end
         end
`ifdef SPI_TX_HDR_EN
         StHdr: begin
            tx_data_d = {id_q, 7'(cnt_q)};
            tx_load_d = 1'b1;
            state_d   = StWaitTx;
         end
`endif
         StFetch: begin
            state_d = StLoad;
         end
         StLoad: begin
            tx_data_d = rd_data_sel;
            tx_load_d = 1'b1;
            cnt_d     = cnt_q - LEN_W'(1);
            state_d   = StWaitTx;
         end
         StWaitTx: begin
            if (send_complete) begin
               state_d = (cnt_q != '0) ? StFetch : StDone;
            end
         end
         StDone: begin
            frame_done_d = gnt_q;
            gnt_d        = 2'b00;
            last_d       = id_q;
            state_d      = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         gnt_q        <= 2'b00;
         id_q         <= 1'b0;
         last_q       <= 1'b1;
         cnt_q        <= '0;
         tx_data_q    <= 8'h00;
         tx_load_q    <= 1'b0;
         frame_done_q <= 2'b00;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         id_q         <= id_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         tx_data_q    <= tx_data_d;
         tx_load_q    <= tx_load_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign gnt        = gnt_q;
   assign rd_en      = (state_q == StFetch);
   assign tx_data    = tx_data_q;
   // Suppress a pending load pulse while reset is being applied.
   assign tx_load    = tx_load_q & ~reset;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != StIdle);

endmodule
